fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a single-cycle synchronous memory.
// Holds the PC, presents instructions with their address and valid flag,
// handles taken-branch redirects (one bubble) and stalls (hold buffer).
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch/redirect counters.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rd,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [15:0]           redirect_count
`endif
);

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [ADDR_WIDTH-1:0]   target_c;

  // Branch target is relative to the presented instruction, word aligned.
  assign target_c = instr_pc_q + ImmOp;

  // Next-state, PC and presentation logic; a stall freezes everything but the hold buffer.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    hold_d        = hold_q;
    hold_valid_d  = hold_valid_q;
    if (stall) begin
      // Memory keeps re-reading the held PC, so keep the word being presented.
      if (instr_valid_q && !hold_valid_q) begin
        hold_d       = imem_rd;
        hold_valid_d = 1'b1;
      end
    end else begin
      hold_valid_d = 1'b0;
      case (state_q)
        BOOT, BUBBLE: begin
          state_d       = RUN;
          pc_d          = pc_q + ADDR_WIDTH'(4);
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
        end
        RUN: begin
          if (PCsrc && instr_valid_q) begin
            // Fetch issued this edge is the fall-through word; squash it.
            state_d       = BUBBLE;
            pc_d          = {target_c[ADDR_WIDTH-1:2], 2'b00};
            instr_valid_d = 1'b0;
          end else begin
            pc_d          = pc_q + ADDR_WIDTH'(4);
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
          end
        end
        default: begin
          state_d       = BOOT;
          pc_d          = RESET_PC;
          instr_pc_d    = RESET_PC;
          instr_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      hold_q        <= hold_d;
      hold_valid_q  <= hold_valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = hold_valid_q ? hold_q : imem_rd;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;
  logic        redirect_c;

  assign redirect_c = !stall && (state_q == RUN) && instr_valid_q && PCsrc;

  // Saturating event counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (instr_valid_q && !stall && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (redirect_c && (redir_cnt_q != '1))              redir_cnt_d = redir_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic
// checked against an instruction-stream reference model.
module tb_fetch_unit;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          PCsrc;
  logic [AW-1:0] ImmOp;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rd;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   fetch_count;
  logic [15:0]   redirect_count;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCsrc(PCsrc), .ImmOp(ImmOp),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  // 64-word synchronous instruction memory (address bits 7:2).
  logic [31:0] mem [64];
  always @(posedge clk) imem_rd <= mem[imem_addr[7:2]];

  // Reference model: the stream of presented instructions.
  logic          m_valid;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_next;
  logic [31:0]   m_fetches;
  logic [15:0]   m_redirects;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_valid = 1'b0; m_pc = '0; m_next = '0; m_fetches = '0; m_redirects = '0;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
  endtask

  // One clock; model advances with the inputs seen at the edge.
  task automatic tick();
    logic s, b;
    logic [AW-1:0] im;
    s = stall; b = PCsrc; im = ImmOp;
    @(posedge clk);
    if (!s) begin
      if (m_valid && (m_fetches != '1)) m_fetches = m_fetches + 1;
      if (m_valid && b) begin
        m_valid = 1'b0;
        m_next  = (m_pc + im) & ~32'h3;
        if (m_redirects != '1) m_redirects = m_redirects + 1;
      end else begin
        m_valid = 1'b1;
        m_pc    = m_next;
        m_next  = m_next + 32'd4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    fill_linear();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_vec++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
    @(negedge clk); rst = 1'b0; model_reset();
    #1;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(i)) begin
        n_err++;
        $display("FAIL boot_seq%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, instr_valid, instr_pc, instr, 32'(4 * i), 32'(i));
      end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 10 && !(m_valid && m_pc == 32'h10); i++) tick();
    n_vec++; if (instr_pc !== 32'h10) begin n_err++; $display("FAIL br_setup: got %h want 10", instr_pc); end
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    tick();
    PCsrc = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %b want 0", instr_valid); end
    n_vec++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL br_addr: got %h want 8", imem_addr); end
    tick();
    n_vec++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'd2) begin
      n_err++; $display("FAIL br_target: got v=%b pc=%h instr=%h want v=1 pc=8 instr=2", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_stall();
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;  // 0x8 -> 0x4
    tick(); PCsrc = 1'b0; tick();
    n_vec++; if (instr_pc !== 32'h4 || instr !== 32'd1) begin n_err++; $display("FAIL st_setup: got pc=%h instr=%h want 4/1", instr_pc, instr); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== 32'd1) begin
        n_err++; $display("FAIL st_hold%0d: got v=%b pc=%h instr=%h want v=1 pc=4 instr=1", i, instr_valid, instr_pc, instr);
      end
    end
    stall = 1'b0;
    #1;
    n_vec++; if (instr !== 32'd1) begin n_err++; $display("FAIL st_release_hold: got %h want 1", instr); end
    tick();
    n_vec++; if (instr_pc !== 32'h8 || instr !== 32'd2) begin n_err++; $display("FAIL st_after: got pc=%h instr=%h want 8/2", instr_pc, instr); end
  endtask

  task automatic test_stall_branch();
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;  // 0x8 -> 0x0
    tick(); PCsrc = 1'b0; tick();
    n_vec++; if (instr_pc !== 32'h0 || instr !== 32'd0) begin n_err++; $display("FAIL sb_setup: got pc=%h instr=%h want 0/0", instr_pc, instr); end
    stall = 1'b1; PCsrc = 1'b1; ImmOp = 32'h20;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_addr !== 32'h4) begin
        n_err++; $display("FAIL sb_stalled%0d: got v=%b pc=%h addr=%h want v=1 pc=0 addr=4", i, instr_valid, instr_pc, imem_addr);
      end
    end
    stall = 1'b0;
    tick();
    PCsrc = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL sb_bubble: got %b want 0", instr_valid); end
    tick();
    n_vec++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'd8) begin
      n_err++; $display("FAIL sb_target: got v=%b pc=%h instr=%h want v=1 pc=20 instr=8", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_async_reset();
    PCsrc = 1'b1; ImmOp = 32'h4;
    tick();
    PCsrc = 1'b0; stall = 1'b1;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ar_bubble: got %b want 0", instr_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
      n_err++; $display("FAIL ar_immediate: got v=%b addr=%h pc=%h want 0/0/0", instr_valid, imem_addr, instr_pc);
    end
    @(posedge clk);
    @(negedge clk); rst = 1'b0; stall = 1'b0; model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(i)) begin
        n_err++; $display("FAIL ar_restart%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                          i, instr_valid, instr_pc, instr, 32'(4 * i), 32'(i));
      end
    end
  endtask

  task automatic test_wrap();
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC - m_pc;
    tick(); PCsrc = 1'b0; tick();
    n_vec++; if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'd63) begin
      n_err++; $display("FAIL wrap_top: got pc=%h instr=%h want fffffffc/3f", instr_pc, instr);
    end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    tick();
    n_vec++; if (instr_pc !== 32'h0 || instr !== 32'd0) begin n_err++; $display("FAIL wrap_zero: got pc=%h instr=%h want 0/0", instr_pc, instr); end
    PCsrc = 1'b1; ImmOp = 32'h13;  // unaligned offset, low bits dropped
    tick(); PCsrc = 1'b0; tick();
    n_vec++; if (instr_pc !== 32'h10 || instr !== 32'd4) begin n_err++; $display("FAIL align: got pc=%h instr=%h want 10/4", instr_pc, instr); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset();
    tick();
    for (int b = 0; b < 2; b++) begin
      repeat (4) tick();
      PCsrc = 1'b1; ImmOp = 32'h8;
      tick(); PCsrc = 1'b0;
      tick();
    end
    n_vec++; if (fetch_count !== 32'd10) begin n_err++; $display("FAIL perf_fetch: got %0d want 10", fetch_count); end
    n_vec++; if (redirect_count !== 16'd2) begin n_err++; $display("FAIL perf_redirect: got %0d want 2", redirect_count); end
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; stall = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; model_reset();
    for (int c = 0; c < 500; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      PCsrc = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) ImmOp = $urandom;
      else ImmOp = 32'($signed($urandom_range(0, 127)) - 64);
      tick();
      n_vec++;
      if (instr_valid !== m_valid || imem_addr !== m_next ||
          (m_valid && (instr_pc !== m_pc || instr !== mem[m_pc[7:2]]))) begin
        n_err++;
        $display("FAIL rand_c%0d: got v=%b addr=%h pc=%h instr=%h want v=%b addr=%h pc=%h instr=%h",
                 c, instr_valid, imem_addr, instr_pc, instr, m_valid, m_next, m_pc, mem[m_pc[7:2]]);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    n_vec++; if (fetch_count !== m_fetches || redirect_count !== m_redirects) begin
      n_err++; $display("FAIL rand_counters: got %0d/%0d want %0d/%0d", fetch_count, redirect_count, m_fetches, m_redirects);
    end
`endif
    stall = 1'b0; PCsrc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_stall_branch();
    test_async_reset();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
